// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular in-order reorder buffer; allocates rename tags, absorbs
//            out-of-order writebacks, serves operand lookups, retires in order.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int ROB_ENTRY_NUM   = 256,
  parameter int ROB_ENTRY_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  // dispatch
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [4:0]                 alloc_dest,
  output logic [ROB_ENTRY_WIDTH-1:0] alloc_index,
  // writeback
  input  logic                       wb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] wb_index,
  input  logic [31:0]                wb_data,
  input  logic                       wb_mispredict,
  input  logic [31:0]                wb_target,
  // operand lookup
  input  logic [ROB_ENTRY_WIDTH-1:0] q1_index,
  input  logic [ROB_ENTRY_WIDTH-1:0] q2_index,
  output logic                       q1_ready,
  output logic                       q2_ready,
  output logic [31:0]                q1_data,
  output logic [31:0]                q2_data,
  // commit
  output logic                       commit_we,
  output logic [4:0]                 commit_addr,
  output logic [31:0]                commit_data,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_index,
  output logic                       rollback,
  output logic [31:0]                redirect_pc,
  output logic [ROB_ENTRY_WIDTH:0]   count
);

  localparam logic [ROB_ENTRY_WIDTH:0]   c_full     = ROB_ENTRY_NUM[ROB_ENTRY_WIDTH:0];
  localparam logic [ROB_ENTRY_WIDTH-1:0] c_ptr_one  = ROB_ENTRY_WIDTH'(1);
  localparam logic [ROB_ENTRY_WIDTH:0]   c_cnt_one  = (ROB_ENTRY_WIDTH+1)'(1);

  logic [ROB_ENTRY_NUM-1:0]   r_valid;
  logic [ROB_ENTRY_NUM-1:0]   r_done;
  logic [ROB_ENTRY_NUM-1:0]   r_mispred;
  logic [4:0]                 r_dest   [ROB_ENTRY_NUM];
  logic [31:0]                r_data   [ROB_ENTRY_NUM];
  logic [31:0]                r_target [ROB_ENTRY_NUM];

  logic [ROB_ENTRY_WIDTH-1:0] r_head;
  logic [ROB_ENTRY_WIDTH-1:0] r_tail;
  logic [ROB_ENTRY_WIDTH:0]   r_count;

  logic                       r_commit_we;
  logic [4:0]                 r_commit_addr;
  logic [31:0]                r_commit_data;
  logic [ROB_ENTRY_WIDTH-1:0] r_commit_index;
  logic                       r_rollback;
  logic [31:0]                r_redirect_pc;

  logic w_alloc_ready;
  logic w_alloc;
  logic w_wb;
  logic w_commit;
  logic w_flush;
  logic w_q1_hit;
  logic w_q2_hit;

  // Registered state only, so dispatch sees no combinational path from commit.
  assign w_alloc_ready = (r_count < c_full) && !r_rollback;
  assign w_alloc       = alloc_valid && w_alloc_ready;
  assign w_wb          = wb_valid && r_valid[wb_index] && !r_rollback;
  assign w_commit      = r_valid[r_head] && r_done[r_head];
  assign w_flush       = w_commit && r_mispred[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      // Flush wins over a same-cycle allocation.
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_ptr_one;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_ptr_one;
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload is qualified by r_valid everywhere, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_dest[r_tail]    <= alloc_dest;
      r_done[r_tail]    <= 1'b0;
      r_mispred[r_tail] <= 1'b0;
    end
    if (w_wb) begin
      r_done[wb_index]    <= 1'b1;
      r_mispred[wb_index] <= wb_mispredict;
      r_data[wb_index]    <= wb_data;
      r_target[wb_index]  <= wb_target;
    end
  end

  // Commit address/data/index hold their last value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_we    <= 1'b0;
      r_commit_addr  <= '0;
      r_commit_data  <= '0;
      r_commit_index <= '0;
      r_rollback     <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_commit_we <= w_commit && (r_dest[r_head] != 5'd0);
      r_rollback  <= w_flush;
      if (w_commit) begin
        r_commit_addr  <= r_dest[r_head];
        r_commit_data  <= r_data[r_head];
        r_commit_index <= r_head;
      end
      if (w_flush) begin
        r_redirect_pc <= r_target[r_head];
      end
    end
  end

  assign w_q1_hit = wb_valid && (wb_index == q1_index);
  assign w_q2_hit = wb_valid && (wb_index == q2_index);

  assign q1_ready = r_valid[q1_index] && (r_done[q1_index] || w_q1_hit);
  assign q2_ready = r_valid[q2_index] && (r_done[q2_index] || w_q2_hit);
  assign q1_data  = w_q1_hit ? wb_data : r_data[q1_index];
  assign q2_data  = w_q2_hit ? wb_data : r_data[q2_index];

  assign alloc_ready  = w_alloc_ready;
  assign alloc_index  = r_tail;
  assign count        = r_count;
  assign commit_we    = r_commit_we;
  assign commit_addr  = r_commit_addr;
  assign commit_data  = r_commit_data;
  assign commit_index = r_commit_index;
  assign rollback     = r_rollback;
  assign redirect_pc  = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Directed self-checking bench for reorder_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_valid;
  logic         alloc_ready;
  logic [4:0]   alloc_dest;
  logic [W-1:0] alloc_index;
  logic         wb_valid;
  logic [W-1:0] wb_index;
  logic [31:0]  wb_data;
  logic         wb_mispredict;
  logic [31:0]  wb_target;
  logic [W-1:0] q1_index;
  logic [W-1:0] q2_index;
  logic         q1_ready;
  logic         q2_ready;
  logic [31:0]  q1_data;
  logic [31:0]  q2_data;
  logic         commit_we;
  logic [4:0]   commit_addr;
  logic [31:0]  commit_data;
  logic [W-1:0] commit_index;
  logic         rollback;
  logic [31:0]  redirect_pc;
  logic [W:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  reorder_buffer #(.ROB_ENTRY_NUM(256), .ROB_ENTRY_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_dest(alloc_dest), .alloc_index(alloc_index),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .q1_index(q1_index), .q2_index(q2_index),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .commit_we(commit_we), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_index(commit_index),
    .rollback(rollback), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid   = 1'b0;
    alloc_dest    = '0;
    wb_valid      = 1'b0;
    wb_index      = '0;
    wb_data       = '0;
    wb_mispredict = 1'b0;
    wb_target     = '0;
    q1_index      = '0;
    q2_index      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int order [4];
    order = '{3, 1, 2, 0};

    // ---------------- reset state
    do_reset();
    #1;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_index", alloc_index, 0);
    check("rst_commit_we", commit_we, 0);
    check("rst_commit_addr", commit_addr, 0);
    check("rst_commit_data", commit_data, 0);
    check("rst_commit_index", commit_index, 0);
    check("rst_rollback", rollback, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_q1_ready", q1_ready, 0);
    check("rst_q2_ready", q2_ready, 0);
    check("rst_count", count, 0);

    // ---------------- fill all 256 entries
    for (int i = 0; i < 256; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'((i % 31) + 1);
      #1;
      check("fill_index", alloc_index, i);
      check("fill_ready", alloc_ready, 1);
      tick();
    end
    #1;
    check("full_ready", alloc_ready, 0);
    check("full_count", count, 256);
    // 257th request stays pending while head completes
    wb_valid = 1'b1; wb_index = 8'd0; wb_data = 32'h11;
    tick();
    wb_valid = 1'b0;
    #1;
    check("full_count_hold", count, 256);
    check("full_index_hold", alloc_index, 0);
    check("full_ready_on_commit", alloc_ready, 0);
    tick();
    alloc_valid = 1'b0;
    #1;
    check("full_commit_count", count, 255);
    check("full_commit_we", commit_we, 1);
    check("full_commit_index", commit_index, 0);
    check("full_commit_addr", commit_addr, 1);
    check("full_commit_data", commit_data, 32'h11);

    // ---------------- out-of-order writeback, in-order commit
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(5 + i);
      tick();
    end
    alloc_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wb_valid = 1'b1;
      wb_index = 8'(order[j]);
      wb_data  = 32'h1000 + 32'(order[j]);
      tick();
    end
    wb_valid = 1'b0;
    #1;
    check("ord_no_early_commit", commit_we, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ord_we", commit_we, 1);
      check("ord_index", commit_index, i);
      check("ord_addr", commit_addr, 5 + i);
      check("ord_data", commit_data, 32'h1000 + 32'(i));
    end
    tick();
    check("ord_we_after", commit_we, 0);
    check("ord_count_after", count, 0);

    // ---------------- dest 0: retires without register write
    alloc_valid = 1'b1; alloc_dest = 5'd0;
    tick();
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_index = 8'd4; wb_data = 32'h55;
    tick();
    wb_valid = 1'b0;
    #1;
    check("d0_count_pending", count, 1);
    tick();
    check("d0_we", commit_we, 0);
    check("d0_index", commit_index, 4);
    check("d0_count", count, 0);

    // ---------------- mispredict commit flushes
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(10 + i);
      tick();
    end
    alloc_valid = 1'b0;
    wb_valid = 1'b1; wb_index = 8'd1; wb_data = 32'hAA;
    wb_mispredict = 1'b1; wb_target = 32'h0000_0400;
    tick();
    wb_index = 8'd2; wb_data = 32'hBB; wb_mispredict = 1'b0; wb_target = 32'h0;
    tick();
    wb_index = 8'd0; wb_data = 32'hA0;
    tick();
    wb_valid = 1'b0;
    tick();
    // alloc alongside the mispredicted commit is discarded
    alloc_valid = 1'b1; alloc_dest = 5'd20;
    #1;
    check("mp_c0_we", commit_we, 1);
    check("mp_c0_index", commit_index, 0);
    check("mp_c0_addr", commit_addr, 10);
    check("mp_c0_data", commit_data, 32'hA0);
    check("mp_c0_rollback", rollback, 0);
    check("mp_c0_count", count, 2);
    check("mp_c0_ready", alloc_ready, 1);
    tick();
    wb_valid = 1'b1; wb_index = 8'd2; wb_data = 32'hCC;
    #1;
    check("mp_c1_we", commit_we, 1);
    check("mp_c1_index", commit_index, 1);
    check("mp_c1_addr", commit_addr, 11);
    check("mp_c1_data", commit_data, 32'hAA);
    check("mp_rollback", rollback, 1);
    check("mp_redirect", redirect_pc, 32'h400);
    check("mp_ready_low", alloc_ready, 0);
    check("mp_count", count, 0);
    check("mp_alloc_index", alloc_index, 0);
    tick();
    wb_valid = 1'b0;
    alloc_valid = 1'b0;
    q1_index = 8'd2;
    #1;
    check("mp_rollback_pulse", rollback, 0);
    check("mp_we_after", commit_we, 0);
    check("mp_ready_back", alloc_ready, 1);
    check("mp_index_restart", alloc_index, 0);
    check("mp_count_after", count, 0);
    check("mp_q_flushed", q1_ready, 0);
    tick();
    check("mp_no_c2", commit_we, 0);

    // ---------------- wrap-around with shallow occupancy
    do_reset();
    for (int k = 0; k < 300; k++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'((k % 31) + 1);
      wb_valid    = (k >= 1);
      wb_index    = 8'((k - 1) & 255);
      wb_data     = 32'(k - 1);
      #1;
      check("wrap_alloc_index", alloc_index, k & 255);
      if (k >= 3) begin
        check("wrap_we", commit_we, 1);
        check("wrap_index", commit_index, (k - 3) & 255);
        check("wrap_data", commit_data, 32'(k - 3));
        check("wrap_addr", commit_addr, ((k - 3) % 31) + 1);
      end
      tick();
    end
    idle();

    // ---------------- operand lookup with same-cycle bypass
    do_reset();
    alloc_valid = 1'b1; alloc_dest = 5'd3;
    tick();
    alloc_valid = 1'b0;
    q1_index = 8'd0; q2_index = 8'd5;
    #1;
    check("q1_not_ready", q1_ready, 0);
    wb_valid = 1'b1; wb_index = 8'd0; wb_data = 32'hDEAD_BEEF;
    #1;
    check("q1_bypass_ready", q1_ready, 1);
    check("q1_bypass_data", q1_data, 32'hDEAD_BEEF);
    check("q2_invalid", q2_ready, 0);
    tick();
    wb_valid = 1'b0; q2_index = 8'd0;
    #1;
    check("q2_stored_ready", q2_ready, 1);
    check("q2_stored_data", q2_data, 32'hDEAD_BEEF);
    tick();
    wb_valid = 1'b1; wb_index = 8'd5; wb_data = 32'h1234; q2_index = 8'd5;
    #1;
    check("q1_after_commit", q1_ready, 0);
    check("q2_wb_invalid", q2_ready, 0);
    wb_valid = 1'b0;

    // ---------------- reset with pending entries
    do_reset();
    for (int i = 0; i < 10; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    check("pend_count", count, 10);
    wb_valid = 1'b1; wb_index = 8'd0; wb_data = 32'h77;
    tick();
    wb_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("pend_rst_count", count, 0);
    check("pend_rst_we", commit_we, 0);
    check("pend_rst_index", alloc_index, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pend_no_commit", commit_we, 0);
      check("pend_count_zero", count, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
